carry_reduce_pipe: RTL and testbench

Pipelined, parametrised wide bit-reduction engine. It is the successor to the single-register carry-chain AND test block.
- Reduces a WIDTH-bit word to one bit using AND, OR, XOR or NOR, selected per beat.
- Uses a tree of CHUNK-input leaves, with one register level per tree level.
- Carries valid and mode alongside the data and supports a global stall.
- Sits in the compare/ speed-test area, and is also reused as a wide match/zero detector in datapaths.

---
 rtl/carry_reduce_pkg.sv | 54 +++++
 rtl/carry_reduce_level.sv | 89 ++++++++
 rtl/carry_reduce_pipe.sv | 77 +++++++
 tb/tb_carry_reduce_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/carry_reduce_pkg.sv
// carry_reduce_pkg: mode encodings and elaboration-time helpers
// for the pipelined wide bit-reduction tree (level count, widths, bus offsets).
package carry_reduce_pkg;

    localparam logic [1:0] MODE_AND = 2'd0;
    localparam logic [1:0] MODE_OR  = 2'd1;
    localparam logic [1:0] MODE_XOR = 2'd2;
    localparam logic [1:0] MODE_NOR = 2'd3;

    // Number of CHUNK-input levels needed to reduce width bits to one.
    function automatic int clog_chunk(input int width, input int chunk);
        int w;
        int n;
        w = width;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (w > 1) begin
                w = (w + chunk - 1) / chunk;
                n = n + 1;
            end
        end
        return n;
    endfunction

    // Word width after k tree levels (k = 0 is the input word).
    function automatic int level_width(input int width, input int chunk, input int k);
        int w;
        w = width;
        for (int i = 0; i < 64; i++) begin
            if (i < k) begin
                w = (w + chunk - 1) / chunk;
            end
        end
        return w;
    endfunction

    // Offset of level k inside the flat bus holding every level back to back.
    function automatic int level_offset(input int width, input int chunk, input int k);
        int off;
        off = 0;
        for (int j = 0; j < 64; j++) begin
            if (j < k) begin
                off = off + level_width(width, chunk, j);
            end
        end
        return off;
    endfunction

    // Identity element used to fill a partial group.
    function automatic logic pad_bit(input logic [1:0] mode);
        return (mode == MODE_AND);
    endfunction

endpackage

// File: rtl/carry_reduce_level.sv
// carry_reduce_level: one registered tree level, reducing groups of CHUNK bits.
// Ports: clk, rst, ce, i_valid/i_mode/i_dat (IN_W) in; o_valid/o_mode/o_dat (ceil(IN_W/CHUNK)) out.
module carry_reduce_level
    import carry_reduce_pkg::*;
#(
    parameter int IN_W   = 4,
    parameter int CHUNK  = 4,
    parameter int METHOD = 4,
    parameter bit LAST   = 1'b0,
    localparam int OUT_W = (IN_W + CHUNK - 1) / CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             i_valid,
    input  logic [1:0]       i_mode,
    input  logic [IN_W-1:0]  i_dat,
    output logic             o_valid,
    output logic [1:0]       o_mode,
    output logic [OUT_W-1:0] o_dat
);

    localparam int PAD_W = OUT_W * CHUNK;

    logic [PAD_W-1:0] w_pad;
    logic [OUT_W-1:0] w_red;
    logic             r_valid;
    logic [1:0]       r_mode;
    logic [OUT_W-1:0] r_dat;

    always_comb begin
        w_pad = {PAD_W{pad_bit(i_mode)}};
        w_pad[IN_W-1:0] = i_dat;
    end

    // METHOD 4 writes AND/OR as mux chains so the tools can map them onto
    // carry logic; otherwise plain gates. XOR is always plain gates.
    always_comb begin
        logic v_and;
        logic v_or;
        logic v_xor;
        logic v_b;
        w_red = '0;
        v_and = 1'b1;
        v_or  = 1'b0;
        v_xor = 1'b0;
        v_b   = 1'b0;
        for (int g = 0; g < OUT_W; g++) begin
            v_and = 1'b1;
            v_or  = 1'b0;
            v_xor = 1'b0;
            for (int c = 0; c < CHUNK; c++) begin
                v_b = w_pad[g*CHUNK+c];
                if (METHOD == 4) begin
                    v_and = v_b ? v_and : 1'b0;
                    v_or  = v_b ? 1'b1 : v_or;
                end else begin
                    v_and = v_and & v_b;
                    v_or  = v_or | v_b;
                end
                v_xor = v_xor ^ v_b;
            end
            case (i_mode)
                MODE_AND: w_red[g] = v_and;
                MODE_XOR: w_red[g] = v_xor;
                // NOR runs as an OR tree; only the last level inverts.
                MODE_NOR: w_red[g] = LAST ? ~v_or : v_or;
                default:  w_red[g] = v_or;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_mode  <= MODE_AND;
            r_dat   <= '0;
        end else if (ce) begin
            r_valid <= i_valid;
            r_mode  <= i_mode;
            r_dat   <= w_red;
        end
    end

    assign o_valid = r_valid;
    assign o_mode  = r_mode;
    assign o_dat   = r_dat;

endmodule

// File: rtl/carry_reduce_pipe.sv
// carry_reduce_pipe: pipelined WIDTH-bit AND/OR/XOR/NOR reduction, latency 1+LEVELS.
// Ports: clk, rst, ce, in_valid, in_mode[1:0], dat_i[WIDTH] in; out_valid, out_mode[1:0], out.
module carry_reduce_pipe
    import carry_reduce_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int CHUNK  = 4,
    parameter int METHOD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] dat_i,
    output logic             out_valid,
    output logic [1:0]       out_mode,
    output logic             out
);

    localparam int LEVELS = clog_chunk(WIDTH, CHUNK);
    localparam int TOT_W  = level_offset(WIDTH, CHUNK, LEVELS + 1);

    // Every level's word sits in one flat bus; level k at level_offset(k).
    logic [TOT_W-1:0] w_bus;
    logic             w_valid [0:LEVELS];
    logic [1:0]       w_mode  [0:LEVELS];

    logic             r_valid;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_mode  <= MODE_AND;
            r_dat   <= '0;
        end else if (ce) begin
            r_valid <= in_valid;
            r_mode  <= in_mode;
            r_dat   <= dat_i;
        end
    end

    assign w_bus[WIDTH-1:0] = r_dat;
    assign w_valid[0]       = r_valid;
    assign w_mode[0]        = r_mode;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int IW = level_width(WIDTH, CHUNK, k);
        localparam int OW = level_width(WIDTH, CHUNK, k + 1);
        localparam int IO = level_offset(WIDTH, CHUNK, k);
        localparam int OO = level_offset(WIDTH, CHUNK, k + 1);

        carry_reduce_level #(
            .IN_W   (IW),
            .CHUNK  (CHUNK),
            .METHOD (METHOD),
            .LAST   (k == LEVELS - 1)
        ) u_lvl (
            .clk     (clk),
            .rst     (rst),
            .ce      (ce),
            .i_valid (w_valid[k]),
            .i_mode  (w_mode[k]),
            .i_dat   (w_bus[IO +: IW]),
            .o_valid (w_valid[k+1]),
            .o_mode  (w_mode[k+1]),
            .o_dat   (w_bus[OO +: OW])
        );
    end

    assign out_valid = w_valid[LEVELS];
    assign out_mode  = w_mode[LEVELS];
    assign out       = w_bus[TOT_W-1];

endmodule

// File: tb/tb_carry_reduce_pipe.sv
// tb_carry_reduce_pipe: scoreboard bench for two carry_reduce_pipe instances
// (64/4 carry-chain and 10/4 LUT) sharing ce/rst/valid/mode/data.
module tb_carry_reduce_pipe;

    localparam int W0 = 64;
    localparam int W1 = 10;
    localparam int L0 = 4;
    localparam int L1 = 3;

    localparam int K_NONE  = 0;
    localparam int K_RST   = 1;
    localparam int K_ADV   = 2;
    localparam int K_STALL = 3;

    typedef struct {
        logic       exp;
        logic [1:0] mode;
        int         acc;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_mode = 2'd0;
    logic [63:0] dat = '0;

    logic        ov0, o0, ov1, o1;
    logic [1:0]  om0, om1;

    item_t q0[$];
    item_t q1[$];
    int    ce_count = 0;
    int    kind = K_NONE;
    int    checks = 0;
    int    errors = 0;
    logic  pv[2];
    logic  po[2];
    logic [1:0] pom[2];

    always #5 clk = ~clk;

    carry_reduce_pipe #(.WIDTH(W0), .CHUNK(4), .METHOD(4)) u_dut0 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid),
        .in_mode(in_mode), .dat_i(dat),
        .out_valid(ov0), .out_mode(om0), .out(o0)
    );

    carry_reduce_pipe #(.WIDTH(W1), .CHUNK(4), .METHOD(0)) u_dut1 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid),
        .in_mode(in_mode), .dat_i(dat[W1-1:0]),
        .out_valid(ov1), .out_mode(om1), .out(o1)
    );

    function automatic logic ref_red(input logic [1:0] m, input logic [63:0] d, input int w);
        logic [63:0] mask;
        logic [63:0] x;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        x = d & mask;
        case (m)
            2'd0:    return x == mask;
            2'd1:    return x != 64'd0;
            2'd2:    return ^x;
            default: return x == 64'd0;
        endcase
    endfunction

    task automatic chk(input int id, input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL d%0d_%s actual=%0h required=%0h t=%0t", id, nm, act, req, $time);
        end
    endtask

    task automatic mon(input int id, input logic ov, input logic o, input logic [1:0] om);
        item_t it;
        bit    have;
        bit    due;
        int    lat;
        lat  = (id == 0) ? L0 : L1;
        have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) it = (id == 0) ? q0[0] : q1[0];
        if (kind == K_RST) begin
            chk(id, ov === 1'b0, "rst_valid", 64'(ov), 0);
            chk(id, o === 1'b0, "rst_out", 64'(o), 0);
            chk(id, om === 2'd0, "rst_mode", 64'(om), 0);
        end else if (kind == K_ADV) begin
            if (ov === 1'b1) begin
                chk(id, have, "unexpected_out", 1, 0);
                if (have) begin
                    if (id == 0) void'(q0.pop_front());
                    else void'(q1.pop_front());
                    chk(id, o === it.exp, "result", 64'(o), 64'(it.exp));
                    chk(id, om === it.mode, "mode", 64'(om), 64'(it.mode));
                    chk(id, ce_count - it.acc + 1 == lat, "latency",
                        64'(ce_count - it.acc + 1), 64'(lat));
                end
            end else begin
                due = have && (ce_count >= it.acc + lat - 1);
                chk(id, !due && (ov === 1'b0), "missing_out", 64'(ov), 1);
                if (due) begin
                    if (id == 0) void'(q0.pop_front());
                    else void'(q1.pop_front());
                end
            end
        end else if (kind == K_STALL) begin
            chk(id, ov === pv[id], "stall_valid", 64'(ov), 64'(pv[id]));
            if (pv[id] === 1'b1) begin
                chk(id, o === po[id], "stall_out", 64'(o), 64'(po[id]));
                chk(id, om === pom[id], "stall_mode", 64'(om), 64'(pom[id]));
            end
        end
        pv[id]  = ov;
        po[id]  = o;
        pom[id] = om;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            kind = K_RST;
            q0.delete();
            q1.delete();
        end else if (ce) begin
            ce_count++;
            kind = K_ADV;
        end else begin
            kind = K_STALL;
        end
    end

    always @(negedge clk) begin
        if (kind != K_NONE) begin
            mon(0, ov0, o0, om0);
            mon(1, ov1, o1, om1);
        end
    end

    task automatic step(input logic v, input logic [1:0] m, input logic [63:0] d,
                        input logic c, input logic r);
        item_t it;
        @(posedge clk);
        #1;
        rst      = r;
        ce       = c;
        in_valid = v;
        in_mode  = m;
        dat      = d;
        if (!r && c && v) begin
            it.acc  = ce_count + 1;
            it.mode = m;
            it.exp  = ref_red(m, d, W0);
            q0.push_back(it);
            it.exp  = ref_red(m, d, W1);
            q1.push_back(it);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 64'd0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [63:0] d;
        logic [63:0] ones;
        int          pos;
        ones = '1;

        step(0, 2'd0, 0, 1, 1);
        step(0, 2'd0, 0, 1, 1);

        d = ones;
        d[37] = 1'b0;
        step(1, 2'd0, ones, 1, 0);
        step(1, 2'd0, d, 1, 0);
        idle(6);

        step(1, 2'd1, 64'h0, 1, 0);
        step(1, 2'd1, 64'h8000_0000_0000_0000, 1, 0);
        step(1, 2'd3, 64'h0, 1, 0);
        step(1, 2'd2, 64'h3, 1, 0);
        step(1, 2'd2, 64'h7, 1, 0);
        idle(6);

        step(1, 2'd0, ones, 1, 0);
        step(0, 2'd0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 2'd1, ones, 0, 0);
        idle(6);

        step(1, 2'd0, ones, 1, 0);
        step(1, 2'd1, 64'h1, 1, 0);
        step(1, 2'd3, 64'h0, 1, 0);
        step(0, 2'd0, 0, 1, 1);
        idle(6);

        step(1, 2'd0, ones, 1, 0);
        step(1, 2'd1, 64'h200, 1, 0);
        step(1, 2'd2, 64'h201, 1, 0);
        step(1, 2'd3, 64'h400, 1, 0);
        idle(6);

        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 4))
                0: d = ones;
                1: d = 64'd0;
                2: begin
                    d = ones;
                    pos = $urandom_range(0, 63);
                    d[pos] = 1'b0;
                end
                3: begin
                    d = 64'd0;
                    pos = $urandom_range(0, 63);
                    d[pos] = 1'b1;
                end
                default: d = {$urandom, $urandom};
            endcase
            step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), d,
                 $urandom_range(0, 9) < 8, $urandom_range(0, 299) == 0);
        end

        idle(10);
        @(negedge clk);
        chk(0, q0.size() == 0, "drain", 64'(q0.size()), 0);
        chk(1, q1.size() == 0, "drain", 64'(q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
